parity_err_ctrl: RTL and testbench
==================================

PARITY_ERR_CTRL -- requirements
Module: parity_err_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_WIDTH, 32, data bits per request
  PARITY_WIDTH, 4, odd-parity lanes; DATA_WIDTH divisible by PARITY_WIDTH
  N_REQ, 4, requesters; power of 2, min 2
  CNT_WIDTH, 16, error counter width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  i_clk  in  1  clock
  i_rst_n  in  1  asynchronous active-low reset
  i_en  in  1  global enable; low = no new grants
  i_req_valid  in  N_REQ  per-requester request
  i_req_data  in  N_REQ*DATA_WIDTH  packed data; requester n at [n*DATA_WIDTH +: DATA_WIDTH]
  i_req_par  in  N_REQ*PARITY_WIDTH  packed expected odd parity, same packing
  o_req_ready  out  N_REQ  one-hot accept strobe
  o_res_valid  out  1  result strobe, one cycle
  o_res_src  out  $clog2(N_REQ)  requester index of result
  o_res_err  out  PARITY_WIDTH  per-lane mismatch mask
  i_irq_en  in  N_REQ  per-requester interrupt enable
  i_irq_clr  in  N_REQ  write-1-to-clear for o_irq_status
  o_irq_status  out  N_REQ  sticky error flags
  o_irq  out  1  |(o_irq_status & i_irq_en), combinational
  i_cnt_clr  in  1  synchronous clear of o_err_cnt
  o_err_cnt  out  CNT_WIDTH  saturating count of erroneous results

Function
REQ-003 Lane k odd parity SHALL be ~^(data[k*L +: L]), L = DATA_WIDTH/PARITY_WIDTH.
REQ-004 FSM states SHALL be IDLE, CALC, CMP; encoding per shared package.
REQ-005 IDLE: if i_en & |i_req_valid, assert o_req_ready for round-robin winner, capture its data/parity/index, go CALC; else stay IDLE.
REQ-006 CALC: register computed parity of captured data; go CMP unconditionally.
REQ-007 CMP: assert o_res_valid, o_res_src, o_res_err = computed ^ expected; go IDLE.
REQ-008 Handshake SHALL be valid/ready; transfer occurs only when i_req_valid[n] & o_req_ready[n]; o_req_ready SHALL be low in CALC and CMP.
REQ-009 Accept at cycle T SHALL give o_res_valid at T+2; max throughput one request per 3 cycles.
REQ-010 Round-robin pointer SHALL advance to winner+1 (mod N_REQ) on each grant; priority search starts at pointer; pointer unchanged without grant.
REQ-011 i_en low mid-transaction SHALL NOT abort it; CALC and CMP complete.
REQ-012 o_res_src, o_res_err SHALL hold last value outside CMP.
REQ-013 In CMP with o_res_err != 0: o_irq_status[o_res_src] set, o_err_cnt += 1 saturating at all-ones.
REQ-014 i_irq_clr[n] SHALL clear o_irq_status[n] next cycle; set SHALL win over simultaneous clear of same bit.
REQ-015 i_cnt_clr SHALL zero o_err_cnt; increment in same cycle SHALL win (result = 1).
REQ-016 Deasserting i_req_valid while ungranted SHALL be legal; request simply not served.

Reset
REQ-017 i_rst_n low SHALL asynchronously force: state IDLE, RR pointer 0, o_req_ready 0, o_res_valid 0, o_res_src 0, o_res_err 0, o_irq_status 0, o_err_cnt 0, captured registers 0.
REQ-018 Reset mid-transaction SHALL discard it; no o_res_valid after release until a new accept.

Structure
REQ-019 Shared package parity_ctrl_pkg SHALL hold FSM state enum and default parameter constants.
REQ-020 Round-robin grant logic SHALL be sub-module parity_rr_arb (inputs req vector, pointer; output one-hot grant).
REQ-021 Parity lane computation SHALL be a generate loop inside parity_err_ctrl.

Verification
REQ-022 Req0 data 0x00000000 par 0xF -> o_req_ready[0] at T, o_res_valid at T+2, o_res_err 0x0, status 0.
REQ-023 Req2 data 0x00000001 par 0xF -> o_res_err 0x1, o_res_src 2, o_irq_status 0x4, o_err_cnt 1, o_irq 1 iff i_irq_en[2].
REQ-024 All four valid continuously, good parity -> grants 0,1,2,3,0 on accepts 3 cycles apart.
REQ-025 Error on src1 in same cycle as i_irq_clr=0x2 -> o_irq_status[1] stays 1; next clear -> 0.
REQ-026 CNT_WIDTH=2, 5 erroneous requests -> o_err_cnt 3; i_cnt_clr -> 0.
REQ-027 i_rst_n low in CALC -> outputs zero, no o_res_valid after release; i_en low in CALC -> result still at T+2.

Source files
------------

// File: rtl/parity_ctrl_pkg.sv
// Shared definitions for the parity error controller: FSM state encoding and
// default parameter values used by the top level and its arbiter.
package parity_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_CMP  = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_PARITY_WIDTH = 4;
  localparam int DEF_N_REQ        = 4;
  localparam int DEF_CNT_WIDTH    = 16;

endpackage

// File: rtl/parity_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first asserted request found
// when scanning upward from the pointer, wrapping modulo N_REQ.
module parity_rr_arb
  import parity_ctrl_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // N_REQ is a power of two, so the index wraps by plain truncation.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parity_err_ctrl.sv
// Arbitrated odd-parity checker: accepts one request at a time, compares its
// per-lane parity two cycles later, and tracks sticky per-source error flags.
module parity_err_ctrl
  import parity_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PARITY_WIDTH = DEF_PARITY_WIDTH,
  parameter int N_REQ        = DEF_N_REQ,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic [N_REQ-1:0]              i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_data,
  input  logic [N_REQ*PARITY_WIDTH-1:0] i_req_par,
  output logic [N_REQ-1:0]              o_req_ready,
  output logic                          o_res_valid,
  output logic [$clog2(N_REQ)-1:0]      o_res_src,
  output logic [PARITY_WIDTH-1:0]       o_res_err,
  input  logic [N_REQ-1:0]              i_irq_en,
  input  logic [N_REQ-1:0]              i_irq_clr,
  output logic [N_REQ-1:0]              o_irq_status,
  output logic                          o_irq,
  input  logic                          i_cnt_clr,
  output logic [CNT_WIDTH-1:0]          o_err_cnt
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int LANE  = DATA_WIDTH / PARITY_WIDTH;

  state_t                    state_reg;
  logic [IDX_W-1:0]          ptr_reg;
  logic [DATA_WIDTH-1:0]     cap_data_reg;
  logic [PARITY_WIDTH-1:0]   cap_par_reg;
  logic [IDX_W-1:0]          cap_idx_reg;
  logic                      res_valid_reg;
  logic [IDX_W-1:0]          res_src_reg;
  logic [PARITY_WIDTH-1:0]   res_err_reg;
  logic [N_REQ-1:0]          irq_status_reg;
  logic [CNT_WIDTH-1:0]      err_cnt_reg;

  logic [N_REQ-1:0]          grant;
  logic [IDX_W-1:0]          win_idx;
  logic                      accept;
  logic [PARITY_WIDTH-1:0]   lane_par;
  logic                      err_hit;
  logic [N_REQ-1:0]          set_mask;

  parity_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (i_req_valid),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) win_idx = IDX_W'(i);
    end
  end

  assign accept      = (state_reg == ST_IDLE) && i_en && (|i_req_valid);
  assign o_req_ready = accept ? grant : '0;

  for (genvar gi = 0; gi < PARITY_WIDTH; gi++) begin : g_lane
    assign lane_par[gi] = ~^cap_data_reg[gi*LANE +: LANE];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      cap_data_reg  <= '0;
      cap_par_reg   <= '0;
      cap_idx_reg   <= '0;
      res_valid_reg <= 1'b0;
      res_src_reg   <= '0;
      res_err_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          res_valid_reg <= 1'b0;
          if (accept) begin
            cap_data_reg <= i_req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
            cap_par_reg  <= i_req_par[win_idx*PARITY_WIDTH +: PARITY_WIDTH];
            cap_idx_reg  <= win_idx;
            ptr_reg      <= win_idx + IDX_W'(1);
            state_reg    <= ST_CALC;
          end
        end
        ST_CALC: begin
          // Computed parity is registered already folded against the expected value.
          res_err_reg   <= lane_par ^ cap_par_reg;
          res_src_reg   <= cap_idx_reg;
          res_valid_reg <= 1'b1;
          state_reg     <= ST_CMP;
        end
        ST_CMP: begin
          res_valid_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
        default: begin
          res_valid_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign err_hit = res_valid_reg && (|res_err_reg);

  always_comb begin
    set_mask = '0;
    if (err_hit) set_mask[res_src_reg] = 1'b1;
  end

  // A new error always beats a same-cycle clear, for both flags and counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_status_reg <= '0;
      err_cnt_reg    <= '0;
    end else begin
      irq_status_reg <= (irq_status_reg & ~i_irq_clr) | set_mask;
      if (err_hit) begin
        if (i_cnt_clr)
          err_cnt_reg <= CNT_WIDTH'(1);
        else if (err_cnt_reg != {CNT_WIDTH{1'b1}})
          err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
      end else if (i_cnt_clr) begin
        err_cnt_reg <= '0;
      end
    end
  end

  assign o_res_valid  = res_valid_reg;
  assign o_res_src    = res_src_reg;
  assign o_res_err    = res_err_reg;
  assign o_irq_status = irq_status_reg;
  assign o_irq        = |(irq_status_reg & i_irq_en);
  assign o_err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_parity_err_ctrl.sv
// Directed bench for parity_err_ctrl (2-bit error counter to reach saturation
// quickly); one line per transaction, one summary line at the end.
module tb_parity_err_ctrl;

  localparam int DW = 32;
  localparam int PW = 4;
  localparam int NR = 4;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*PW-1:0] req_par = '0;
  logic [NR-1:0]  irq_en = '0;
  logic [NR-1:0]  irq_clr = '0;
  logic           cnt_clr = 1'b0;

  logic [NR-1:0]  req_ready;
  logic           res_valid;
  logic [1:0]     res_src;
  logic [PW-1:0]  res_err;
  logic [NR-1:0]  irq_status;
  logic           irq;
  logic [CW-1:0]  err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  parity_err_ctrl #(
    .DATA_WIDTH   (DW),
    .PARITY_WIDTH (PW),
    .N_REQ        (NR),
    .CNT_WIDTH    (CW)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_par    (req_par),
    .o_req_ready  (req_ready),
    .o_res_valid  (res_valid),
    .o_res_src    (res_src),
    .o_res_err    (res_err),
    .i_irq_en     (irq_en),
    .i_irq_clr    (irq_clr),
    .o_irq_status (irq_status),
    .o_irq        (irq),
    .i_cnt_clr    (cnt_clr),
    .o_err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single request from idx, entered while in IDLE; returns in IDLE after CMP.
  task automatic run_req(input int idx, input logic [31:0] data, input logic [3:0] par,
                         input logic [3:0] exp_err, input logic [3:0] clr_in_cmp,
                         input logic cnt_clr_in_cmp);
    req_data = '0;
    req_par  = '0;
    req_data[idx*DW +: DW] = data;
    req_par[idx*PW +: PW]  = par;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    #1;
    check("ready_accept", req_ready, 32'(1 << idx));
    tick;
    req_valid = '0;
    #1;
    check("ready_calc", req_ready, 0);
    check("valid_calc", res_valid, 0);
    tick;
    irq_clr = clr_in_cmp;
    cnt_clr = cnt_clr_in_cmp;
    check("valid_cmp", res_valid, 1);
    check("src_cmp", res_src, idx);
    check("err_cmp", res_err, exp_err);
    tick;
    irq_clr = '0;
    cnt_clr = 1'b0;
    check("valid_after", res_valid, 0);
    check("err_hold", res_err, exp_err);
    check("src_hold", res_src, idx);
    $display("txn src=%0d data=0x%08h par=0x%0h err=0x%0h status=0x%0h cnt=%0d",
             idx, data, par, res_err, irq_status, err_cnt);
  endtask

  initial begin
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_valid", res_valid, 0);
    check("rst_src", res_src, 0);
    check("rst_err", res_err, 0);
    check("rst_status", irq_status, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_irq", irq, 0);
    rst_n = 1'b1;
    tick;

    // All requesters valid with good parity: grants rotate 0,1,2,3,0.
    req_data  = '0;
    req_par   = '1;
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_grant", req_ready, 32'(1 << (k % 4)));
      tick;
      check("rr_ready_calc", req_ready, 0);
      tick;
      check("rr_valid", res_valid, 1);
      check("rr_src", res_src, k % 4);
      check("rr_err", res_err, 0);
      $display("txn rr accept=%0d src=%0d err=0x%0h", k, res_src, res_err);
      tick;
    end
    req_valid = '0;

    run_req(0, 32'h0000_0000, 4'hF, 4'h0, 4'h0, 1'b0);
    check("good_status", irq_status, 0);
    check("good_cnt", err_cnt, 0);

    run_req(2, 32'h0000_0001, 4'hF, 4'h1, 4'h0, 1'b0);
    check("err_status", irq_status, 4'h4);
    check("err_cnt1", err_cnt, 1);
    check("irq_masked", irq, 0);
    irq_en = 4'h4;
    #1;
    check("irq_enabled", irq, 1);
    irq_en = '0;
    irq_clr = 4'h4;
    tick;
    irq_clr = '0;
    check("status_clr", irq_status, 0);

    // Set beats a same-cycle clear on the same bit.
    run_req(1, 32'h0000_0001, 4'hF, 4'h1, 4'h0, 1'b0);
    check("src1_status", irq_status, 4'h2);
    check("err_cnt2", err_cnt, 2);
    run_req(1, 32'h0000_0001, 4'hF, 4'h1, 4'h2, 1'b0);
    check("set_wins", irq_status, 4'h2);
    check("err_cnt3", err_cnt, 3);
    irq_clr = 4'h2;
    tick;
    irq_clr = '0;
    check("src1_clr", irq_status, 0);

    run_req(3, 32'h0000_0100, 4'hF, 4'h2, 4'h0, 1'b0);
    check("sat_cnt4", err_cnt, 3);
    run_req(0, 32'h8000_0000, 4'hF, 4'h8, 4'h0, 1'b0);
    check("sat_cnt5", err_cnt, 3);
    check("status_30", irq_status, 4'h9);
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    check("cnt_clr", err_cnt, 0);

    // Increment beats a same-cycle counter clear.
    run_req(2, 32'h0001_0000, 4'hF, 4'h4, 4'h0, 1'b1);
    check("inc_wins", err_cnt, 1);
    check("status_d", irq_status, 4'hD);
    irq_en = 4'h2;
    #1;
    check("irq_off_bit", irq, 0);
    irq_en = 4'hF;
    #1;
    check("irq_all", irq, 1);
    irq_en = '0;

    // Reset while in CALC discards the transaction.
    req_data = '0;
    req_par  = '0;
    req_valid = 4'h2;
    #1;
    check("rstmid_ready", req_ready, 4'h2);
    tick;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", res_valid, 0);
    check("rstmid_src", res_src, 0);
    check("rstmid_err", res_err, 0);
    check("rstmid_status", irq_status, 0);
    check("rstmid_cnt", err_cnt, 0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("rstmid_no_valid", res_valid, 0);
    end
    $display("txn reset-in-calc discarded");

    // Dropping enable mid-transaction does not abort it.
    req_par = '1;
    req_valid = 4'h8;
    #1;
    check("en_ready", req_ready, 4'h8);
    tick;
    req_valid = '0;
    en = 1'b0;
    tick;
    check("en_valid", res_valid, 1);
    check("en_src", res_src, 3);
    check("en_err", res_err, 0);
    tick;
    req_valid = 4'h1;
    #1;
    check("en_low_ready", req_ready, 0);
    tick;
    tick;
    check("en_low_no_valid", res_valid, 0);
    $display("txn enable-low-in-calc src=3 completed");
    req_valid = '0;
    en = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
